// File: rtl/spi_flash_responder.sv
// SPI mode-0 single-bit flash target answering READ (0x03) from a byte-wide synchronous memory.
// Other opcodes are swallowed until chip select rises; unknown ones pulse cmd_err.
module spi_flash_responder #(
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              core_clk,
    input  logic              core_rstn,
    input  logic              flash_csb,
    input  logic              flash_clk,
    input  logic              flash_io0,
    output logic              flash_io1,
    output logic              flash_io1_oeb,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StIgnore} state_e;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] csb_sync, clk_sync, io0_sync;
    logic                   csb_s, clk_s, io0_s, clk_prev_q, clk_rise, clk_fall;

    state_e            state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [23:0]       sh_q, sh_d, sh_next;
    logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
    logic [7:0]        tx_q, tx_d, pf_q, pf_d, src;
    logic              mem_rd_q, mem_rd_d, rd_vld_q, rd_vld_d, dst_pf_q, dst_pf_d;
    logic              first_q, first_d, io1_q, io1_d, oeb_q, oeb_d, cmd_err_q, cmd_err_d;

    assign csb_s    = csb_sync[SYNC_STAGES-1];
    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign io0_s    = io0_sync[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_prev_q;
    assign clk_fall = ~clk_s & clk_prev_q;

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            csb_sync   <= '1;
            clk_sync   <= '0;
            io0_sync   <= '0;
            clk_prev_q <= 1'b0;
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            sh_q       <= '0;
            addr_q     <= '0;
            mem_addr_q <= '0;
            tx_q       <= '0;
            pf_q       <= '0;
            mem_rd_q   <= 1'b0;
            rd_vld_q   <= 1'b0;
            dst_pf_q   <= 1'b0;
            first_q    <= 1'b0;
            io1_q      <= 1'b0;
            oeb_q      <= 1'b1;
            cmd_err_q  <= 1'b0;
        end else begin
            csb_sync   <= {csb_sync[SYNC_STAGES-2:0], flash_csb};
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], flash_clk};
            io0_sync   <= {io0_sync[SYNC_STAGES-2:0], flash_io0};
            clk_prev_q <= clk_s;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sh_q       <= sh_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            tx_q       <= tx_d;
            pf_q       <= pf_d;
            mem_rd_q   <= mem_rd_d;
            rd_vld_q   <= rd_vld_d;
            dst_pf_q   <= dst_pf_d;
            first_q    <= first_d;
            io1_q      <= io1_d;
            oeb_q      <= oeb_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sh_d       = sh_q;
        addr_d     = addr_q;
        mem_addr_d = mem_addr_q;
        tx_d       = tx_q;
        pf_d       = pf_q;
        mem_rd_d   = 1'b0;
        rd_vld_d   = mem_rd_q;
        dst_pf_d   = dst_pf_q;
        first_d    = first_q;
        io1_d      = io1_q;
        oeb_d      = oeb_q;
        cmd_err_d  = 1'b0;
        sh_next    = {sh_q[22:0], io0_s};
        src        = tx_q;

        // Read data lands one cycle after the strobe; route it to the current or prefetch byte.
        if (rd_vld_q) begin
            if (dst_pf_q) pf_d = mem_rdata;
            else          tx_d = mem_rdata;
        end

        if (state_q != StIdle && csb_s) begin
            state_d   = StIdle;
            io1_d     = 1'b0;
            oeb_d     = 1'b1;
            rd_vld_d  = 1'b0;
            bit_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    io1_d    = 1'b0;
                    oeb_d    = 1'b1;
                    rd_vld_d = 1'b0;
                    if (!csb_s) begin
                        state_d   = StCmd;
                        bit_cnt_d = '0;
                        sh_d      = '0;
                        // A rise seen together with the select belongs to the new frame.
                        if (clk_rise) begin
                            bit_cnt_d = 5'd1;
                            sh_d      = {23'd0, io0_s};
                        end
                    end
                end
                StCmd: begin
                    if (clk_rise) begin
                        sh_d      = sh_next;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = '0;
                            sh_d      = '0;
                            if (sh_next[7:0] == 8'h03) begin
                                state_d = StAddr;
                            end else begin
                                state_d   = StIgnore;
                                cmd_err_d = !(sh_next[7:0] == 8'hAB || sh_next[7:0] == 8'hFF);
                            end
                        end
                    end
                end
                StAddr: begin
                    if (clk_rise) begin
                        sh_d      = sh_next;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d  = '0;
                            addr_d     = sh_next[ADDR_W-1:0];
                            mem_addr_d = sh_next[ADDR_W-1:0];
                            mem_rd_d   = 1'b1;
                            dst_pf_d   = 1'b0;
                            first_d    = 1'b1;
                            state_d    = StData;
                        end
                    end
                end
                StData: begin
                    if (clk_fall) begin
                        if (bit_cnt_q[2:0] == 3'd0) begin
                            if (!first_q) src = pf_q;
                            first_d    = 1'b0;
                            addr_d     = addr_q + ADDR_ONE;
                            mem_addr_d = addr_q + ADDR_ONE;
                            mem_rd_d   = 1'b1;
                            dst_pf_d   = 1'b1;
                        end
                        io1_d     = src[7];
                        tx_d      = {src[6:0], 1'b0};
                        oeb_d     = 1'b0;
                        bit_cnt_d = {2'b00, bit_cnt_q[2:0] + 3'd1};
                    end
                end
                StIgnore: begin
                    oeb_d = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign flash_io1     = io1_q;
    assign flash_io1_oeb = oeb_q;
    assign mem_rd        = mem_rd_q;
    assign mem_addr      = mem_addr_q;
    assign busy          = (state_q != StIdle);
    assign cmd_err       = cmd_err_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: table of SPI frames, memory-read scoreboard,
// plus hand-written abort and mid-transfer reset sequences.
module tb_spi_flash_responder;

    localparam int AW = 8;
    localparam int H  = 80;   // SPI half period in ns (8 core clocks)

    logic          core_clk = 1'b0;
    logic          core_rstn;
    logic          flash_csb, flash_clk, flash_io0;
    logic          flash_io1, flash_io1_oeb, mem_rd, busy, cmd_err;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;

    spi_flash_responder #(
        .ADDR_W      (AW),
        .SYNC_STAGES (2)
    ) dut (
        .core_clk      (core_clk),
        .core_rstn     (core_rstn),
        .flash_csb     (flash_csb),
        .flash_clk     (flash_clk),
        .flash_io0     (flash_io0),
        .flash_io1     (flash_io1),
        .flash_io1_oeb (flash_io1_oeb),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .busy          (busy),
        .cmd_err       (cmd_err)
    );

    always #5 core_clk = ~core_clk;

    logic [7:0] mem [256];
    always @(posedge core_clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    typedef struct {
        logic [7:0]  op;
        logic [23:0] addr;
        int          n;
        int          err;
    } vec_t;

    int            errors = 0;
    int            checks = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] obs_q[$];
    int            err_cycles = 0;
    int            oeb_low_cycles = 0;

    always @(negedge core_clk) begin
        if (cmd_err) err_cycles++;
        if (!flash_io1_oeb) oeb_low_cycles++;
        if (mem_rd) obs_q.push_back(mem_addr);
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, output logic oe_all);
        oe_all = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            flash_io0 = tx[i];
            #(H);
            rx[i] = flash_io1;
            if (flash_io1_oeb) oe_all = 1'b0;
            flash_clk = 1'b1;
            #(H);
            flash_clk = 1'b0;
        end
    endtask

    task automatic clock_bits(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            flash_io0 = 1'b1;
            #(H);
            flash_clk = 1'b1;
            #(H);
            flash_clk = 1'b0;
        end
    endtask

    task automatic compare_reads(input string tag);
        logic [AW-1:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s mem_rd_missing: got no read, expected addr %0h", tag, e);
            end else begin
                check({tag, " mem_addr"}, 32'(obs_q.pop_front()), 32'(e));
            end
        end
        while (obs_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s mem_rd_extra: got addr %0h, expected no read", tag, obs_q.pop_front());
        end
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int         e0, o0;
        logic [7:0] rx, ai;
        logic       oe;
        e0 = err_cycles;
        o0 = oeb_low_cycles;
        flash_clk = 1'b0;
        flash_csb = 1'b0;
        #(H);
        check({tag, " busy_sel"}, 32'(busy), 32'd1);
        xfer(v.op, rx, oe);
        if (v.op == 8'h03) begin
            for (int i = 0; i <= v.n; i++) exp_q.push_back(v.addr[AW-1:0] + AW'(i));
            xfer(v.addr[23:16], rx, oe);
            xfer(v.addr[15:8], rx, oe);
            xfer(v.addr[7:0], rx, oe);
            for (int k = 0; k < v.n; k++) begin
                xfer(8'h00, rx, oe);
                ai = v.addr[7:0] + 8'(k);
                check({tag, " data"}, 32'(rx), 32'(mem[ai]));
                check({tag, " data_oe"}, 32'(oe), 32'd1);
            end
        end else begin
            xfer(8'h5A, rx, oe);
            xfer(8'hC3, rx, oe);
            check({tag, " oeb_held"}, 32'(oeb_low_cycles - o0), 32'd0);
        end
        flash_csb = 1'b1;
        #(4 * H);
        check({tag, " busy_idle"}, 32'(busy), 32'd0);
        check({tag, " oeb_idle"}, 32'(flash_io1_oeb), 32'd1);
        check({tag, " cmd_err_cycles"}, 32'(err_cycles - e0), 32'(v.err));
        compare_reads(tag);
    endtask

    vec_t       vecs[5];
    vec_t       v;
    logic [7:0] rx;
    logic       oe;
    int         e0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
        mem[0]    = 8'h6F;
        mem[1]    = 8'h00;
        mem[2]    = 8'h00;
        mem[3]    = 8'h13;
        mem[8'h10] = 8'hC3;
        mem[8'hFE] = 8'h5A;
        mem[8'hFF] = 8'hA5;

        vecs[0] = '{8'h03, 24'h000000, 4, 0};
        vecs[1] = '{8'h03, 24'hAB12FE, 3, 0};   // upper bits ignored, wraps FE,FF,00
        vecs[2] = '{8'hAB, 24'h000000, 0, 0};
        vecs[3] = '{8'h9F, 24'h000000, 0, 1};
        vecs[4] = '{8'hFF, 24'h000000, 0, 0};

        core_rstn = 1'b0;
        flash_csb = 1'b1;
        flash_clk = 1'b0;
        flash_io0 = 1'b0;
        #23;
        core_rstn = 1'b1;
        #40;
        check("rst io1", 32'(flash_io1), 32'd0);
        check("rst oeb", 32'(flash_io1_oeb), 32'd1);
        check("rst mem_rd", 32'(mem_rd), 32'd0);
        check("rst mem_addr", 32'(mem_addr), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst cmd_err", 32'(cmd_err), 32'd0);

        for (int t = 0; t < 5; t++) run_txn(vecs[t], $sformatf("vec%0d", t));

        // Abort after 12 address bits, then a clean read at 0x10.
        e0 = err_cycles;
        flash_csb = 1'b0;
        #(H);
        xfer(8'h03, rx, oe);
        xfer(8'hFF, rx, oe);
        clock_bits(4);
        flash_csb = 1'b1;
        #(4 * H);
        check("abort no_mem_rd", 32'(obs_q.size()), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort cmd_err", 32'(err_cycles - e0), 32'd0);
        v = '{8'h03, 24'h000010, 2, 0};
        run_txn(v, "post_abort");

        // Reset in the middle of the third data byte.
        flash_csb = 1'b0;
        #(H);
        xfer(8'h03, rx, oe);
        xfer(8'h00, rx, oe);
        xfer(8'h00, rx, oe);
        xfer(8'h00, rx, oe);
        xfer(8'h00, rx, oe);
        xfer(8'h00, rx, oe);
        clock_bits(3);
        #(H / 2);
        core_rstn = 1'b0;
        #1;
        check("midrst oeb", 32'(flash_io1_oeb), 32'd1);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst mem_rd", 32'(mem_rd), 32'd0);
        check("midrst io1", 32'(flash_io1), 32'd0);
        flash_csb = 1'b1;
        #(H);
        core_rstn = 1'b1;
        #(4 * H);
        obs_q.delete();
        exp_q.delete();
        v = '{8'h03, 24'h000000, 4, 0};
        run_txn(v, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
Synthesizable SPI flash target (mode 0, single-bit) that answers the management SoC's flash controller: it accepts flash_csb/flash_clk/flash_io0 from the SoC and drives data back on flash_io1. Read data comes from a byte-wide synchronous memory port (ROM or RAM loaded with the firmware image), so the SoC can boot from on-die or FPGA memory instead of a behavioural flash model. Serves standalone DV benches and FPGA bring-up of mgmt_core_wrapper.

Parameters:
ADDR_W, 24, memory address width; SPI address bits above ADDR_W ignored, address wraps mod 2^ADDR_W
SYNC_STAGES, 2, synchronizer depth for flash_csb, flash_clk, flash_io0 (min 2)

Ports:
core_clk  input  1  system clock; all logic on rising edge
core_rstn  input  1  asynchronous active-low reset
flash_csb  input  1  chip select from SoC, active low
flash_clk  input  1  SPI clock from SoC, idle low (mode 0)
flash_io0  input  1  serial data SoC->responder (MOSI)
flash_io1  output  1  serial data responder->SoC (MISO)
flash_io1_oeb  output  1  output enable for flash_io1, active low
mem_rd  output  1  one-cycle read strobe
mem_addr  output  ADDR_W  byte address for mem_rd
mem_rdata  input  8  read data, valid exactly 1 core_clk after mem_rd
busy  output  1  high while selected (synchronized csb low)
cmd_err  output  1  one-cycle pulse when an unsupported opcode completes

Behaviour:
- Reset: flash_io1=0, flash_io1_oeb=1, mem_rd=0, mem_addr=0, busy=0, cmd_err=0, state IDLE, sync regs preset csb=1, clk=0, io0=0.
- Inputs pass through SYNC_STAGES flops; rise/fall of flash_clk detected on synchronized value. Legal only if flash_clk high and low phases each >= 6 core_clk.
- States: IDLE, CMD, ADDR, DATA, IGNORE.
- IDLE: sync csb falls -> CMD, bit counter=0, busy=1.
- CMD: shift flash_io0 MSB-first on each clk rise; after 8th bit: 0x03 -> ADDR; 0xAB or 0xFF -> IGNORE, no error; any other -> IGNORE plus cmd_err pulse in the cycle after the 8th rise.
- ADDR: shift 24 bits MSB-first; on 24th rise, load address register (low ADDR_W bits), mem_rd=1 with mem_addr=that address for one cycle; next cycle capture mem_rdata into tx shift reg, enter DATA.
- DATA: on each clk fall drive flash_io1 = tx_reg[7] then shift left; flash_io1_oeb=0 from first fall in DATA. On the fall driving bit 7 of a byte, increment address (wrap 2^ADDR_W -> 0) and pulse mem_rd; capture into a prefetch reg; on fall after bit 0 of the current byte, load prefetch into tx_reg and drive its bit 7. Unbounded streaming.
- IGNORE: no output, flash_io1_oeb=1; wait for csb rise.
- csb rise in any state (incl. mid-byte, mid-address): next cycle -> IDLE, flash_io1=0, flash_io1_oeb=1, busy=0, partial shifts discarded; an in-flight mem_rd completes but data dropped. Flash_clk edges while csb high ignored.
- csb fall and clk edge same sync cycle: csb processed first; edge belongs to new transaction.
- Async reset mid-transaction: all outputs return to reset values immediately.

Test Plan:
- Read at 0x000000, memory[0..3]=0x6F,0x00,0x00,0x13: csb low, send 0x03,0x00,0x00,0x00, clock 32 bits -> flash_io1 bytes 0x6F,0x00,0x00,0x13 MSB-first; mem_rd pulses with mem_addr 0,1,2,3(,4 prefetch).
- Wrap: ADDR_W=8, read from 0xFE for 3 bytes -> data from 0xFE,0xFF,0x00; mem_addr sequence 0xFE,0xFF,0x00.
- Opcode 0xAB then 0x9F: 0xAB -> no cmd_err, oeb stays 1; 0x9F -> cmd_err exactly one cycle, flash_io1_oeb=1 for remainder.
- csb rise after 12 address bits, then new 0x03 read at 0x000010 -> returns memory[0x10], no residue from aborted frame.
- Async reset asserted during DATA byte 2 -> flash_io1_oeb=1, busy=0, mem_rd=0 same cycle; post-reset read at 0 correct.
- Full boot: connect to mgmt_core_wrapper with mem test image -> la_output[31:16] reaches 0xAB11 with no 0xAB40/0xAB20/0xAB10.
